// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back queue: address/data widths,
// the queued request payload and the bypass lookup result.
package wb_pkg;

   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned WORDSIZE = 64;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [WORDSIZE-1:0] data;
   } wb_req_t;

   typedef struct packed {
      logic                hit;
      logic [WORDSIZE-1:0] data;
   } byp_rsp_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Producer, register-file and bypass signals of the write-back queue.
// Optional WBQ_DROP_CNT_EN adds the drop_cnt output.
interface writeback_queue_if #(parameter int unsigned DEPTH = 4);
   import wb_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic                alu_valid;
   logic                alu_ready;
   logic [ADDR_W-1:0]   alu_addr;
   logic [WORDSIZE-1:0] alu_data;
   logic                mem_valid;
   logic                mem_ready;
   logic [ADDR_W-1:0]   mem_addr;
   logic [WORDSIZE-1:0] mem_data;
   logic                drain_hold;
   logic                rf_write_en;
   logic [ADDR_W-1:0]   rf_write_addr;
   logic [WORDSIZE-1:0] rf_write_data;
   logic [ADDR_W-1:0]   byp_addr_a;
   logic [ADDR_W-1:0]   byp_addr_b;
   logic                byp_hit_a;
   logic                byp_hit_b;
   logic [WORDSIZE-1:0] byp_data_a;
   logic [WORDSIZE-1:0] byp_data_b;
   logic [CNT_W-1:0]    count;
`ifdef WBQ_DROP_CNT_EN
   logic [15:0]         drop_cnt;
`endif

   modport master (
      output alu_valid, alu_addr, alu_data,
      output mem_valid, mem_addr, mem_data,
      output drain_hold, byp_addr_a, byp_addr_b,
      input  alu_ready, mem_ready,
      input  rf_write_en, rf_write_addr, rf_write_data,
      input  byp_hit_a, byp_hit_b, byp_data_a, byp_data_b,
`ifdef WBQ_DROP_CNT_EN
      input  drop_cnt,
`endif
      input  count
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data,
      input  mem_valid, mem_addr, mem_data,
      input  drain_hold, byp_addr_a, byp_addr_b,
      output alu_ready, mem_ready,
      output rf_write_en, rf_write_addr, rf_write_data,
      output byp_hit_a, byp_hit_b, byp_data_a, byp_data_b,
`ifdef WBQ_DROP_CNT_EN
      output drop_cnt,
`endif
      output count
   );

endinterface

// File: rtl/wbq_fifo.sv
// In-order circular buffer of pending register writes; exposes all storage
// and the head pointer so the parent can run the bypass search.
module wbq_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  wb_req_t                      push_data_i,
   input  logic                         pop_i,
   output wb_req_t                      head_data_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH):0]       count_o,
   output logic [$clog2(DEPTH)-1:0]     head_ptr_o,
   output wb_req_t [DEPTH-1:0]          entries_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_req_t [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0]    head_q, head_d;
   logic [PTR_W-1:0]    tail_q, tail_d;
   logic [CNT_W-1:0]    count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
      if (push_i) tail_d = tail_q + PTR_W'(1);
      if (pop_i)  head_d = head_q + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: only entries covered by count are ever read.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[tail_q] <= push_data_i;
   end

   assign head_data_o = mem_q[head_q];
   assign empty_o     = (count_q == '0);
   assign count_o     = count_q;
   assign head_ptr_o  = head_q;
   assign entries_o   = mem_q;

endmodule

// File: rtl/writeback_queue.sv
// Write-back queue in front of the register file: arbitrates ALU/load results,
// filters x0, retires one entry per cycle and offers a bypass lookup.
// Optional feature: WBQ_DROP_CNT_EN adds a saturating x0-drop counter.
module writeback_queue
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   writeback_queue_if.slave  wbq
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_req_t              req;
   wb_req_t              head;
   wb_req_t [DEPTH-1:0]  entries;
   logic [PTR_W-1:0]     head_ptr;
   logic [CNT_W-1:0]     fifo_count;
   logic                 empty;
   logic                 accept;
   logic                 push;
   logic                 pop;
   logic                 ready_q, ready_d;
   byp_rsp_t             byp_a, byp_b;

   // Youngest valid entry wins: scan oldest to youngest, last match sticks.
   function automatic byp_rsp_t lookup(input logic [ADDR_W-1:0] a,
                                       input wb_req_t [DEPTH-1:0] ents,
                                       input logic [PTR_W-1:0] hd,
                                       input logic [CNT_W-1:0] cnt);
      byp_rsp_t         r;
      logic [PTR_W-1:0] idx;
      r = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = hd + PTR_W'(i);
         if ((CNT_W'(i) < cnt) && (a != REG_ZERO) && (ents[idx].addr == a)) begin
            r.hit  = 1'b1;
            r.data = ents[idx].data;
         end
      end
      return r;
   endfunction

   // Loads have priority; ready depends on registered occupancy only.
   assign wbq.mem_ready = ready_q;
   assign wbq.alu_ready = ready_q && !wbq.mem_valid;

   always_comb begin
      req    = '0;
      accept = 1'b0;
      if (wbq.mem_valid) begin
         req.addr = wbq.mem_addr;
         req.data = wbq.mem_data;
         accept   = ready_q;
      end else if (wbq.alu_valid) begin
         req.addr = wbq.alu_addr;
         req.data = wbq.alu_data;
         accept   = ready_q;
      end
   end

   assign push = accept && (req.addr != REG_ZERO);
   assign pop  = !empty && !wbq.drain_hold;

   assign ready_d = (fifo_count + CNT_W'(push) - CNT_W'(pop)) != CNT_W'(DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_q <= 1'b0;
      else        ready_q <= ready_d;
   end

   wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i (req),
      .pop_i       (pop),
      .head_data_o (head),
      .empty_o     (empty),
      .count_o     (fifo_count),
      .head_ptr_o  (head_ptr),
      .entries_o   (entries)
   );

   assign wbq.rf_write_en   = pop;
   assign wbq.rf_write_addr = pop ? head.addr : '0;
   assign wbq.rf_write_data = pop ? head.data : '0;
   assign wbq.count         = fifo_count;

   always_comb begin
      byp_a = lookup(wbq.byp_addr_a, entries, head_ptr, fifo_count);
      byp_b = lookup(wbq.byp_addr_b, entries, head_ptr, fifo_count);
   end

   assign wbq.byp_hit_a  = byp_a.hit;
   assign wbq.byp_data_a = byp_a.data;
   assign wbq.byp_hit_b  = byp_b.hit;
   assign wbq.byp_data_b = byp_b.data;

`ifdef WBQ_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Saturating count of accepted x0 writes.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (accept && (req.addr == REG_ZERO) && (drop_cnt_q != 16'hFFFF))
         drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign wbq.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: a queue model of pending writes
// predicts ready, retirement order, occupancy and bypass results.
module tb_writeback_queue;
   import wb_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   writeback_queue_if #(.DEPTH(DEPTH)) wbq ();

   writeback_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wbq   (wbq)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending writes in arrival order, plus reset bookkeeping.
   wb_req_t model_q[$];
   bit      armed = 1'b0;
   int      drop_model = 0;

   function automatic void model_byp(input logic [ADDR_W-1:0] a,
                                     output logic hit, output logic [63:0] data);
      hit = 1'b0;
      data = '0;
      if (a != 0) begin
         for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (model_q[i].addr == a) begin
               hit = 1'b1;
               data = model_q[i].data;
               break;
            end
         end
      end
   endfunction

   // Monitor: compares every cycle on the falling edge, then advances the model.
   always @(negedge clk) begin
      logic         exp_ready, exp_we, h;
      logic [63:0]  d;
      wb_req_t      nreq;
      if (!rst_n) begin
         model_q.delete();
         armed = 1'b0;
         drop_model = 0;
         check("rst_we",    64'(wbq.rf_write_en), 64'd0);
         check("rst_addr",  64'(wbq.rf_write_addr), 64'd0);
         check("rst_data",  wbq.rf_write_data, 64'd0);
         check("rst_count", 64'(wbq.count), 64'd0);
         check("rst_ready", 64'({wbq.mem_ready, wbq.alu_ready}), 64'd0);
         check("rst_byp",   64'({wbq.byp_hit_a, wbq.byp_hit_b}), 64'd0);
         check("rst_bdat",  wbq.byp_data_a | wbq.byp_data_b, 64'd0);
      end else begin
         exp_ready = armed && (model_q.size() < DEPTH);
         check("mem_ready", 64'(wbq.mem_ready), 64'(exp_ready));
         check("alu_ready", 64'(wbq.alu_ready), 64'(exp_ready && !wbq.mem_valid));
         check("count", 64'(wbq.count), 64'(model_q.size()));
         exp_we = (model_q.size() > 0) && !wbq.drain_hold;
         check("rf_we", 64'(wbq.rf_write_en), 64'(exp_we));
         if (exp_we) begin
            check("rf_addr", 64'(wbq.rf_write_addr), 64'(model_q[0].addr));
            check("rf_data", wbq.rf_write_data, model_q[0].data);
         end else begin
            check("rf_addr_idle", 64'(wbq.rf_write_addr), 64'd0);
            check("rf_data_idle", wbq.rf_write_data, 64'd0);
         end
         model_byp(wbq.byp_addr_a, h, d);
         check("byp_hit_a", 64'(wbq.byp_hit_a), 64'(h));
         check("byp_data_a", wbq.byp_data_a, d);
         model_byp(wbq.byp_addr_b, h, d);
         check("byp_hit_b", 64'(wbq.byp_hit_b), 64'(h));
         check("byp_data_b", wbq.byp_data_b, d);
`ifdef WBQ_DROP_CNT_EN
         check("drop_cnt", 64'(wbq.drop_cnt), 64'(drop_model));
`endif
         if (exp_we) void'(model_q.pop_front());
         if (exp_ready && (wbq.mem_valid || wbq.alu_valid)) begin
            nreq.addr = wbq.mem_valid ? wbq.mem_addr : wbq.alu_addr;
            nreq.data = wbq.mem_valid ? wbq.mem_data : wbq.alu_data;
            if (nreq.addr != 0) model_q.push_back(nreq);
            else if (drop_model < 65535) drop_model++;
         end
         armed = 1'b1;
      end
   end

   // One clock of stimulus; producers drop valid once their handshake completes.
   task automatic tick();
      logic acc_m, acc_a;
      @(negedge clk);
      acc_m = wbq.mem_valid && wbq.mem_ready;
      acc_a = wbq.alu_valid && wbq.alu_ready;
      @(posedge clk);
      #1;
      if (acc_m) wbq.mem_valid = 1'b0;
      if (acc_a) wbq.alu_valid = 1'b0;
   endtask

   task automatic set_alu(input logic [ADDR_W-1:0] a, input logic [63:0] d);
      wbq.alu_valid = 1'b1;
      wbq.alu_addr  = a;
      wbq.alu_data  = d;
   endtask

   task automatic set_mem(input logic [ADDR_W-1:0] a, input logic [63:0] d);
      wbq.mem_valid = 1'b1;
      wbq.mem_addr  = a;
      wbq.mem_data  = d;
   endtask

   task automatic wait_accept(input int budget);
      int n = 0;
      while ((wbq.mem_valid || wbq.alu_valid) && n < budget) begin
         tick();
         n++;
      end
      check("accept_timeout", 64'(wbq.mem_valid || wbq.alu_valid), 64'd0);
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (wbq.count != 0 && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", 64'(wbq.count), 64'd0);
   endtask

   initial begin
      wbq.alu_valid = 1'b0; wbq.alu_addr = '0; wbq.alu_data = '0;
      wbq.mem_valid = 1'b0; wbq.mem_addr = '0; wbq.mem_data = '0;
      wbq.drain_hold = 1'b0;
      wbq.byp_addr_a = '0;  wbq.byp_addr_b = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Single ALU write, retired the cycle after acceptance.
      set_alu(5'd3, 64'hAA);
      wait_accept(10);
      wait_empty(10);

      // Load and ALU together: load first, ALU one cycle later.
      set_mem(5'd5, 64'h55);
      set_alu(5'd6, 64'h66);
      wait_accept(10);
      wait_empty(10);

      // Fill under drain_hold, then release.
      wbq.drain_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_alu(5'(10 + i), 64'(32'h1000 + i));
         wait_accept(10);
      end
      check("full_count", 64'(wbq.count), 64'd4);
      check("full_alu_ready", 64'(wbq.alu_ready), 64'd0);
      check("full_we", 64'(wbq.rf_write_en), 64'd0);
      set_alu(5'd20, 64'hF00D);
      repeat (3) tick();
      check("full_held", 64'(wbq.alu_valid), 64'd1);
      wbq.drain_hold = 1'b0;
      wait_accept(10);
      wait_empty(20);

      // Youngest match wins in the bypass; x0 never hits.
      wbq.drain_hold = 1'b1;
      set_alu(5'd7, 64'h11);
      wait_accept(10);
      set_alu(5'd7, 64'h22);
      wait_accept(10);
      wbq.byp_addr_a = 5'd7;
      wbq.byp_addr_b = 5'd0;
      #1;
      check("byp_young_hit", 64'(wbq.byp_hit_a), 64'd1);
      check("byp_young_data", wbq.byp_data_a, 64'h22);
      check("byp_x0_hit", 64'(wbq.byp_hit_b), 64'd0);
      tick();
      wbq.drain_hold = 1'b0;
      wait_empty(10);

      // Write to x0 is accepted and dropped.
      set_alu(5'd0, 64'hDEAD);
      wait_accept(10);
      tick();
      check("x0_count", 64'(wbq.count), 64'd0);
`ifdef WBQ_DROP_CNT_EN
      check("x0_drop_cnt", 64'(wbq.drop_cnt), 64'd1);
`endif

      // Reset mid-cycle with three entries pending.
      wbq.drain_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_alu(5'(1 + i), 64'(32'hBEEF0 + i));
         wait_accept(10);
      end
      wbq.byp_addr_a = 5'd2;
      #2 rst_n = 1'b0;
      #1;
      check("pulse_we", 64'(wbq.rf_write_en), 64'd0);
      check("pulse_count", 64'(wbq.count), 64'd0);
      check("pulse_hit", 64'({wbq.byp_hit_a, wbq.byp_hit_b}), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      wbq.drain_hold = 1'b0;
      repeat (5) tick();

      // Random traffic with holds, x0 writes and bypass probes.
      for (int c = 0; c < 3000; c++) begin
         if (!wbq.mem_valid && ($urandom % 3 == 0))
            set_mem(5'($urandom % 8), {$urandom, $urandom});
         if (!wbq.alu_valid && ($urandom % 2 == 0))
            set_alu(5'($urandom % 8), {$urandom, $urandom});
         wbq.drain_hold = ($urandom % 4 == 0);
         wbq.byp_addr_a = 5'($urandom % 8);
         wbq.byp_addr_b = 5'($urandom % 8);
         tick();
      end
      wbq.drain_hold = 1'b0;
      wait_accept(20);
      wait_empty(20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
